pipelined_fixed_shifter: RTL
============================

PIPELINED_FIXED_SHIFTER -- requirements
Module: pipelined_fixed_shifter

Interface
REQ-001 SHALL provide parameter MANTISSABITS, default 23, number of stored mantissa bits; the normal bit is appended as MSB.
REQ-002 SHALL provide parameter FIXEDSIZE, default 16, unsigned fixed-point output width.
REQ-003 SHALL provide parameter RADIXPOINTSIZE, default 6, shift-amount width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  reset; asynchronous, active-low.
REQ-006 InNormFloat  input  MANTISSABITS+1  mantissa with normal bit as MSB.
REQ-007 InShiftAmount  input  RADIXPOINTSIZE  shift distance.
REQ-008 InShiftDirection  input  1  0 = left shift, 1 = right shift.
REQ-009 InValid  input  1  input beat present.
REQ-010 InReady  output  1  block can accept a beat this cycle.
REQ-011 OutUFixed  output  FIXEDSIZE  shifted, rounded, saturated result.
REQ-012 OutOverflow  output  1  result saturated to all-ones.
REQ-013 OutInexact  output  1  nonzero bits were discarded by a right shift.
REQ-014 OutValid  output  1  output beat present.
REQ-015 OutReady  input  1  downstream accepts the output beat.

Function
REQ-016 SHALL be a two-stage pipeline: stage 1 registers the inputs; stage 2 registers the shift/round/saturate result.
REQ-017 A beat SHALL be accepted on a cycle where InValid and InReady are both 1.
REQ-018 OutValid SHALL assert two cycles after acceptance when there is no backpressure.
REQ-019 InReady SHALL equal !V1 || !V2 || OutReady, where V1 and V2 are the stage valid bits; InReady has no combinational dependence on InValid.
REQ-020 Stage 2 SHALL load from stage 1 when !V2 || OutReady.
REQ-021 Stage 2 output and OutValid SHALL hold stable while OutValid && !OutReady.
REQ-022 Beats SHALL leave in acceptance order; the block SHALL sustain one beat per cycle with no loss or duplication.
REQ-023 Left shift: the full product InNormFloat << InShiftAmount SHALL be formed without truncation.
REQ-024 Left shift: if any product bit at or above position FIXEDSIZE is 1, then OutUFixed SHALL be all-ones and OutOverflow SHALL be 1; otherwise OutUFixed is the product's low FIXEDSIZE bits and OutOverflow is 0.
REQ-025 Right shift: truncated result T = InNormFloat >> InShiftAmount.
REQ-026 Right shift: guard bit G = bit InShiftAmount-1 of InNormFloat, or 0 when InShiftAmount is 0.
REQ-027 Right shift: sticky bit S = OR of all InNormFloat bits below the guard position.
REQ-028 Right shift with InShiftAmount > MANTISSABITS+1: T = 0, G = 0, S = OR of all input bits.
REQ-029 OutInexact SHALL be G | S for right shifts and 0 for left shifts.
REQ-030 Right shift: if T, after rounding, exceeds 2^FIXEDSIZE-1, the saturation rule of REQ-024 SHALL apply.
REQ-031 InNormFloat = 0 SHALL yield OutUFixed = 0, OutOverflow = 0 and OutInexact = 0 in either direction.

Reset
REQ-032 While Rst_n = 0, V1, V2, OutValid, OutUFixed, OutOverflow and OutInexact SHALL be 0, and InReady SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight beats immediately, independent of Clk.
REQ-034 The first accept after reset deassertion SHALL be possible on the first rising edge at which Rst_n = 1.

Configuration
REQ-035 Macro ROUNDING_EN defined: right shifts SHALL round to nearest, ties to even, i.e. T+1 when G && (S || T[0]), otherwise T.
REQ-036 Macro ROUNDING_EN undefined: right shifts SHALL truncate (result T) and OutInexact SHALL be tied to 0; interface and latency are unchanged.

Verification (defaults MANTISSABITS=23, FIXEDSIZE=16, RADIXPOINTSIZE=6)
REQ-037 Exact right shift: 0x800000 >> 23, OutReady=1 -> OutUFixed=0x0001, OutInexact=0, OutOverflow=0, OutValid exactly 2 cycles after accept.
REQ-038 Rounding: 0xC00000 >> 23 -> 0x0002 with OutInexact=1 under ROUNDING_EN; 0x0001 with OutInexact=0 without it.
REQ-039 Tie-to-even: 0xA00000 >> 22 -> 0x0002 with OutInexact=1 under ROUNDING_EN.
REQ-040 Saturation: 0x800000 << 0 -> 0xFFFF with OutOverflow=1; 0x800000 >> 8 -> 0x8000 with OutOverflow=0.
REQ-041 Backpressure: OutReady=0 with 3 back-to-back beats -> InReady drops after 2 accepts; on release, outputs appear in order with the third beat intact.
REQ-042 Reset mid-flight: Rst_n pulsed low with 2 beats in flight -> OutValid=0 at once, no stale beat after release, InReady=1.

Source files
------------

// File: rtl/pipelined_fixed_shifter.sv
// Two-stage pipelined mantissa-to-unsigned-fixed shifter with saturation and valid/ready flow control.
// Optional build macro ROUNDING_EN enables round-to-nearest-even on right shifts and the OutInexact flag.
module pipelined_fixed_shifter #(
    parameter int MANTISSABITS   = 23,
    parameter int FIXEDSIZE      = 16,
    parameter int RADIXPOINTSIZE = 6
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [MANTISSABITS:0]     InNormFloat,
    input  logic [RADIXPOINTSIZE-1:0] InShiftAmount,
    input  logic                      InShiftDirection,
    input  logic                      InValid,
    output logic                      InReady,
    output logic [FIXEDSIZE-1:0]      OutUFixed,
    output logic                      OutOverflow,
    output logic                      OutInexact,
    output logic                      OutValid,
    input  logic                      OutReady
);

    localparam int unsigned W  = MANTISSABITS + 1;
    // Wide enough to hold the mantissa shifted left by the largest encodable amount.
    localparam int unsigned PW = W + (1 << RADIXPOINTSIZE) - 1;

    logic                      v1;
    logic                      v2;
    logic [W-1:0]              mant;
    logic [RADIXPOINTSIZE-1:0] amt;
    logic                      dir;
    logic                      load2;

    logic [PW-1:0] product;
    logic [PW-1:0] truncated;
    logic [PW-1:0] rounded;
    logic [PW-1:0] value;
    logic          round_up;
    logic          overflow;
    logic          inexact;
`ifdef ROUNDING_EN
    logic          guard;
    logic          sticky;
`endif

    assign load2    = !v2 || OutReady;
    assign InReady  = !v1 || load2;
    assign OutValid = v2;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            v1   <= 1'b0;
            mant <= '0;
            amt  <= '0;
            dir  <= 1'b0;
        end else if (InReady) begin
            v1 <= InValid;
            if (InValid) begin
                mant <= InNormFloat;
                amt  <= InShiftAmount;
                dir  <= InShiftDirection;
            end
        end
    end

    always_comb begin
        product   = PW'(mant) << amt;
        truncated = PW'(mant >> amt);
`ifdef ROUNDING_EN
        guard  = 1'b0;
        sticky = 1'b0;
        // Guard is the bit just below the new LSB; amounts past the top leave only sticky.
        for (int unsigned i = 0; i < W; i++) begin
            if (i + 1 == 32'(amt)) begin
                guard = mant[i];
            end else if (i + 1 < 32'(amt)) begin
                sticky = sticky | mant[i];
            end
        end
        round_up = guard && (sticky || truncated[0]);
        inexact  = dir && (guard || sticky);
`else
        round_up = 1'b0;
        inexact  = 1'b0;
`endif
        rounded  = truncated + PW'(round_up);
        value    = dir ? rounded : product;
        overflow = |value[PW-1:FIXEDSIZE];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            v2          <= 1'b0;
            OutUFixed   <= '0;
            OutOverflow <= 1'b0;
            OutInexact  <= 1'b0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                OutUFixed   <= overflow ? '1 : value[FIXEDSIZE-1:0];
                OutOverflow <= overflow;
                OutInexact  <= inexact;
            end
        end
    end

endmodule
